// File: rtl/wi23_defs.sv
// Shared instruction-memory definitions: geometry plus the data-port arbiter's
// state, requester id and read-tag types.
package wi23_defs;

  localparam int IMEM_DEPTH = 10;
  localparam int IMEM_WIDTH = 16;

  typedef enum logic [1:0] {
    ARB,
    DBG_BURST,
    CPU_YIELD
  } imem_arb_state_t;

  typedef enum logic {
    REQ_CPU,
    REQ_DBG
  } imem_req_id_t;

  typedef struct packed {
    logic         vld;
    imem_req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/imem_dport_arb_if.sv
// Requester and memory-side bundle of the instruction-memory data-port arbiter.
// The slave view belongs to the arbiter; the master view to whatever drives it.
interface imem_dport_arb_if import wi23_defs::*; ();

  logic                  cpu_req_i;
  logic [IMEM_DEPTH-1:0] cpu_addr_i;
  logic                  cpu_gnt_o;
  logic                  cpu_rvalid_o;
  logic                  dbg_req_i;
  logic                  dbg_we_i;
  logic [IMEM_DEPTH-1:0] dbg_addr_i;
  logic [IMEM_WIDTH-1:0] dbg_wdata_i;
  logic                  dbg_lock_i;
  logic                  dbg_gnt_o;
  logic                  dbg_rvalid_o;
  logic [IMEM_WIDTH-1:0] rdata_o;
  logic [IMEM_DEPTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [IMEM_WIDTH-1:0] mem_wdata_o;
  logic [IMEM_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_addr_i,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_lock_i,
    input  mem_rdata_i,
    output cpu_gnt_o, cpu_rvalid_o, dbg_gnt_o, dbg_rvalid_o, rdata_o,
    output mem_addr_o, mem_we_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_addr_i,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_lock_i,
    output mem_rdata_i,
    input  cpu_gnt_o, cpu_rvalid_o, dbg_gnt_o, dbg_rvalid_o, rdata_o,
    input  mem_addr_o, mem_we_o, mem_wdata_o
  );

endinterface

// File: rtl/imem_dport_arb_rd_tag_pipe.sv
// Two-stage read tag shift register: stage 0 marks the cycle the memory is read,
// stage 1 produces the per-requester rvalid pulse alongside the registered data.
module imem_rd_tag_pipe import wi23_defs::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld_i,
  input  imem_req_id_t push_id_i,
  output logic         capture_o,
  output logic         cpu_rvalid_o,
  output logic         dbg_rvalid_o
);

  rd_tag_t s0_q, s1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q.vld <= push_vld_i;
      s0_q.id  <= push_id_i;
      s1_q     <= s0_q;
    end
  end

  assign capture_o    = s0_q.vld;
  assign cpu_rvalid_o = s1_q.vld && (s1_q.id == REQ_CPU);
  assign dbg_rvalid_o = s1_q.vld && (s1_q.id == REQ_DBG);

endmodule

// File: rtl/imem_dport_arb.sv
// Shares the instruction memory's data port between the CPU load path and the
// debug/loader link; one grant per cycle, read data returned two cycles after grant.
//
//   state     | meaning
//   ARB       | round-robin between CPU and debug
//   DBG_BURST | debug owns the port while it holds lock
//   CPU_YIELD | one forced CPU slot after a full burst
module imem_dport_arb import wi23_defs::*; #(
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  imem_dport_arb_if.slave  bus
);

  localparam int            CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  imem_arb_state_t       state_q;
  logic [CW-1:0]         burst_cnt_q;
  imem_req_id_t          last_gnt_q;
  logic                  cpu_gnt;
  logic                  dbg_gnt;
  logic                  burst_at_max;

  logic [IMEM_DEPTH-1:0] mem_addr_q;
  logic                  mem_we_q;
  logic [IMEM_WIDTH-1:0] mem_wdata_q;
  logic [IMEM_WIDTH-1:0] rdata_q;
  logic                  push_vld;
  imem_req_id_t          push_id;
  logic                  capture;

  assign burst_at_max = (burst_cnt_q == BURST_MAX);

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    unique case (state_q)
      ARB: begin
        if (bus.cpu_req_i && bus.dbg_req_i) begin
          cpu_gnt = (last_gnt_q == REQ_DBG);
          dbg_gnt = (last_gnt_q == REQ_CPU);
        end else begin
          cpu_gnt = bus.cpu_req_i;
          dbg_gnt = bus.dbg_req_i;
        end
      end
      // The slot where a full burst meets a waiting CPU is left empty.
      DBG_BURST: dbg_gnt = bus.dbg_req_i && !(burst_at_max && bus.cpu_req_i);
      CPU_YIELD: cpu_gnt = bus.cpu_req_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      burst_cnt_q <= '0;
      last_gnt_q  <= REQ_DBG;
    end else begin
      if (cpu_gnt)      last_gnt_q <= REQ_CPU;
      else if (dbg_gnt) last_gnt_q <= REQ_DBG;

      unique case (state_q)
        ARB: begin
          if (dbg_gnt && bus.dbg_lock_i) begin
            state_q     <= DBG_BURST;
            burst_cnt_q <= CW'(1);
          end
        end
        DBG_BURST: begin
          if (burst_at_max && bus.cpu_req_i) begin
            state_q <= CPU_YIELD;
          end else if (!bus.dbg_lock_i) begin
            state_q     <= ARB;
            burst_cnt_q <= '0;
          end else if (dbg_gnt && !burst_at_max) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
        end
        CPU_YIELD: begin
          burst_cnt_q <= '0;
          state_q     <= bus.dbg_lock_i ? DBG_BURST : ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign push_vld = cpu_gnt || (dbg_gnt && !bus.dbg_we_i);
  assign push_id  = dbg_gnt ? REQ_DBG : REQ_CPU;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      mem_we_q <= dbg_gnt && bus.dbg_we_i;
      if (cpu_gnt) begin
        mem_addr_q <= bus.cpu_addr_i;
      end else if (dbg_gnt) begin
        mem_addr_q <= bus.dbg_addr_i;
        if (bus.dbg_we_i) mem_wdata_q <= bus.dbg_wdata_i;
      end
      // Memory output settles on the negedge of the cycle after grant.
      if (capture) rdata_q <= bus.mem_rdata_i;
    end
  end

  imem_rd_tag_pipe u_tag_pipe (
    .clk          (clk),
    .rst          (rst),
    .push_vld_i   (push_vld),
    .push_id_i    (push_id),
    .capture_o    (capture),
    .cpu_rvalid_o (bus.cpu_rvalid_o),
    .dbg_rvalid_o (bus.dbg_rvalid_o)
  );

  assign bus.cpu_gnt_o   = cpu_gnt;
  assign bus.dbg_gnt_o   = dbg_gnt;
  assign bus.rdata_o     = rdata_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_imem_dport_arb.sv
// Directed bench for imem_dport_arb: a negedge memory model, a reference memory
// and a read-return scoreboard keyed by the expected return cycle.
module tb_imem_dport_arb;
  import wi23_defs::*;

  typedef logic [IMEM_WIDTH-1:0] word_t;
  typedef logic [IMEM_DEPTH-1:0] addr_t;
  typedef struct {
    imem_req_id_t id;
    word_t        data;
    int           due;
  } sb_t;

  localparam int NWORDS = 1 << IMEM_DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_dport_arb_if ifc ();
  imem_dport_arb #(.MAX_BURST(8)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  word_t mem     [NWORDS];
  word_t ref_mem [NWORDS];
  sb_t   sb [$];

  int    n_cmp = 0;
  int    n_bad = 0;
  int    tick_no;
  logic  prev_v, prev_we;
  addr_t prev_addr, last_addr;
  word_t prev_wdata;
  logic  obs_cpu_gnt, obs_dbg_gnt, obs_cpu_rv, obs_dbg_rv;
  word_t obs_rdata;

  function automatic word_t pat(input int i);
    return word_t'(i * 37 + 291);
  endfunction

  // Memory writes before it reads, both on the negedge.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) mem[i] = pat(i);
      ifc.mem_rdata_i = '0;
    end else begin
      if (ifc.mem_we_o) mem[ifc.mem_addr_o] = ifc.mem_wdata_o;
      ifc.mem_rdata_i = mem[ifc.mem_addr_o];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, exp, tick_no);
    end
  endtask

  task automatic drive(input logic creq, input addr_t caddr, input logic dreq, input logic dwe,
                       input addr_t daddr, input word_t dwd, input logic lock);
    ifc.cpu_req_i   = creq;
    ifc.cpu_addr_i  = caddr;
    ifc.dbg_req_i   = dreq;
    ifc.dbg_we_i    = dwe;
    ifc.dbg_addr_i  = daddr;
    ifc.dbg_wdata_i = dwd;
    ifc.dbg_lock_i  = lock;
  endtask

  task automatic tick();
    sb_t  e;
    logic exp_c, exp_d;
    @(negedge clk);
    #1;
    obs_cpu_gnt = ifc.cpu_gnt_o;
    obs_dbg_gnt = ifc.dbg_gnt_o;
    obs_cpu_rv  = ifc.cpu_rvalid_o;
    obs_dbg_rv  = ifc.dbg_rvalid_o;
    obs_rdata   = ifc.rdata_o;
    chk("gnt_exclusive", obs_cpu_gnt & obs_dbg_gnt, 0);
    chk("rvalid_exclusive", obs_cpu_rv & obs_dbg_rv, 0);
    if (prev_v) begin
      chk("mem_addr", ifc.mem_addr_o, prev_addr);
      chk("mem_we", ifc.mem_we_o, prev_we);
      if (prev_we) chk("mem_wdata", ifc.mem_wdata_o, prev_wdata);
    end else begin
      chk("mem_we_idle", ifc.mem_we_o, 0);
      chk("mem_addr_hold", ifc.mem_addr_o, last_addr);
    end
    exp_c = 1'b0;
    exp_d = 1'b0;
    if (sb.size() > 0 && sb[0].due == tick_no) begin
      e = sb.pop_front();
      exp_c = (e.id == REQ_CPU);
      exp_d = (e.id == REQ_DBG);
      chk("rdata", obs_rdata, e.data);
    end
    chk("cpu_rvalid", obs_cpu_rv, exp_c);
    chk("dbg_rvalid", obs_dbg_rv, exp_d);
    prev_v = obs_cpu_gnt | obs_dbg_gnt;
    prev_we = 1'b0;
    if (obs_cpu_gnt) begin
      e.id = REQ_CPU; e.data = ref_mem[ifc.cpu_addr_i]; e.due = tick_no + 2;
      sb.push_back(e);
      prev_addr = ifc.cpu_addr_i;
    end else if (obs_dbg_gnt) begin
      prev_addr = ifc.dbg_addr_i;
      if (ifc.dbg_we_i) begin
        prev_we = 1'b1;
        prev_wdata = ifc.dbg_wdata_i;
        ref_mem[ifc.dbg_addr_i] = ifc.dbg_wdata_i;
      end else begin
        e.id = REQ_DBG; e.data = ref_mem[ifc.dbg_addr_i]; e.due = tick_no + 2;
        sb.push_back(e);
      end
    end
    if (prev_v) last_addr = prev_addr;
    tick_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input string tag, input logic c, input logic d);
    chk({tag, "_cpu_gnt"}, obs_cpu_gnt, c);
    chk({tag, "_dbg_gnt"}, obs_dbg_gnt, d);
  endtask

  task automatic chk_reset_vals();
    @(negedge clk);
    #1;
    chk("rst_cpu_gnt", ifc.cpu_gnt_o, 0);
    chk("rst_dbg_gnt", ifc.dbg_gnt_o, 0);
    chk("rst_cpu_rvalid", ifc.cpu_rvalid_o, 0);
    chk("rst_dbg_rvalid", ifc.dbg_rvalid_o, 0);
    chk("rst_mem_we", ifc.mem_we_o, 0);
    chk("rst_mem_addr", ifc.mem_addr_o, 0);
    chk("rst_mem_wdata", ifc.mem_wdata_o, 0);
    chk("rst_rdata", ifc.rdata_o, 0);
  endtask

  task automatic clear_model();
    sb.delete();
    prev_v = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wdata = '0; last_addr = '0;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = pat(i);
  endtask

  initial begin
    tick_no = 0;
    rst = 1'b1;
    drive(0, '0, 0, 0, '0, '0, 0);
    clear_model();
    @(posedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Both requesting, no lock: strict alternation, CPU first after reset.
    drive(1, 10'h030, 1, 0, 10'h040, '0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_gnt("alternate", (i % 2) == 0, (i % 2) == 1);
    end
    drive(0, '0, 0, 0, '0, '0, 0);
    repeat (3) tick();

    // CPU-only back-to-back reads.
    for (int i = 0; i < 3; i++) begin
      drive(1, addr_t'(10'h010 + i), 0, 0, '0, '0, 0);
      tick();
      exp_gnt("cpu_only", 1, 0);
    end
    drive(0, '0, 0, 0, '0, '0, 0);
    repeat (3) tick();

    // Debug write followed by read of the same word.
    drive(0, '0, 1, 1, 10'h020, 16'hBEEF, 0);
    tick();
    exp_gnt("dbg_write", 0, 1);
    drive(0, '0, 1, 0, 10'h020, '0, 0);
    tick();
    exp_gnt("dbg_read", 0, 1);
    drive(0, '0, 0, 0, '0, '0, 0);
    tick();
    tick();
    chk("wr_rd_dbg_rvalid", obs_dbg_rv, 1);
    chk("wr_rd_cpu_rvalid", obs_cpu_rv, 0);
    chk("wr_rd_data", obs_rdata, 16'hBEEF);
    tick();

    // Locked burst with the CPU waiting: 8 debug, empty slot, 1 CPU, repeat.
    drive(1, 10'h050, 1, 0, 10'h060, '0, 1);
    tick();
    exp_gnt("lock_first_tie", 1, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        tick();
        exp_gnt("lock_dbg", 0, 1);
      end
      tick();
      exp_gnt("lock_gap", 0, 0);
      tick();
      exp_gnt("lock_cpu", 1, 0);
    end
    drive(0, '0, 0, 0, '0, '0, 0);
    repeat (3) tick();

    // Locked with idle CPU: burst count saturates, no yield until the CPU asks.
    drive(0, '0, 1, 0, 10'h070, '0, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_gnt("sat_dbg", 0, 1);
    end
    drive(1, 10'h071, 1, 0, 10'h070, '0, 1);
    tick();
    exp_gnt("sat_gap", 0, 0);
    tick();
    exp_gnt("sat_cpu", 1, 0);
    drive(0, '0, 0, 0, '0, '0, 0);
    repeat (3) tick();

    // Reset with two reads in flight; CPU granted last so the tie proves last_gnt reset.
    drive(0, '0, 1, 0, 10'h081, '0, 0);
    tick();
    exp_gnt("pre_rst_dbg", 0, 1);
    drive(1, 10'h080, 0, 0, '0, '0, 0);
    tick();
    exp_gnt("pre_rst_cpu", 1, 0);
    drive(0, '0, 0, 0, '0, '0, 0);
    rst = 1'b1;
    clear_model();
    chk_reset_vals();
    @(posedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) tick();
    drive(1, 10'h090, 1, 0, 10'h091, '0, 0);
    tick();
    exp_gnt("post_rst_tie", 1, 0);
    tick();
    exp_gnt("post_rst_tie2", 0, 1);
    drive(0, '0, 0, 0, '0, '0, 0);
    repeat (3) tick();

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_dport_arb.md
# imem_dport_arb

Arbiter for the instruction memory's secondary (data) port. It shares that port between two requesters. The CPU load path reads constants and jump tables from instruction memory. The debug/loader path reads and writes program words over the host link. The arbiter sits between both requesters and the dual-port instruction memory. It grants at most one transfer per cycle, pipelines the address and write strobes, and returns read data with a fixed latency.

## Interface
Parameters:
- IMEM_DEPTH, from wi23_defs: address width in bits.
- IMEM_WIDTH, from wi23_defs: word width in bits.
- MAX_BURST, default 8: maximum consecutive debug grants while locked, before the CPU must be served.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_i  in  1  CPU read request; held until granted.
- cpu_addr_i  in  IMEM_DEPTH  CPU read address.
- cpu_gnt_o  out  1  CPU request accepted this cycle.
- cpu_rvalid_o  out  1  CPU read data valid on rdata_o.
- dbg_req_i  in  1  debug request; held until granted.
- dbg_we_i  in  1  1 = write, 0 = read.
- dbg_addr_i  in  IMEM_DEPTH  debug address.
- dbg_wdata_i  in  IMEM_WIDTH  debug write data.
- dbg_lock_i  in  1  debug requests burst ownership.
- dbg_gnt_o  out  1  debug request accepted this cycle.
- dbg_rvalid_o  out  1  debug read data valid on rdata_o.
- rdata_o  out  IMEM_WIDTH  shared read-return data.
- mem_addr_o  out  IMEM_DEPTH  to the memory's data-port address.
- mem_we_o  out  1  memory write strobe.
- mem_wdata_o  out  IMEM_WIDTH  memory write data.
- mem_rdata_i  in  IMEM_WIDTH  memory data-port read output, updated on negedge.

## Operation
States:
- ARB: round-robin between requesters.
- DBG_BURST: debug owns the port.
- CPU_YIELD: one forced CPU slot.

Grant rules:
- ARB with one requester: grant it.
- ARB with both requesting: grant the one not granted most recently (last_gnt). last_gnt resets to DBG, so the CPU wins the first tie.
- ARB: a debug grant with dbg_lock_i=1 moves to DBG_BURST and sets burst_cnt=1.
- DBG_BURST:
  - Debug is granted whenever dbg_req_i=1; each grant increments burst_cnt.
  - When burst_cnt==MAX_BURST and cpu_req_i=1, move to CPU_YIELD and do not grant debug.
  - When burst_cnt==MAX_BURST and the CPU is idle, burst_cnt holds at MAX_BURST and debug keeps being granted. burst_cnt saturates and never wraps.
  - dbg_lock_i=0 returns to ARB next cycle.
  - A CPU request while burst_cnt<MAX_BURST waits.
- CPU_YIELD: grant the CPU once (it is requesting), clear burst_cnt, then return to DBG_BURST if dbg_lock_i=1, else ARB.
- Grant outputs are combinational from state and requests. They are one-hot or zero, never both high.

Datapath:
- A granted transfer registers its address into mem_addr_o.
- A granted write also registers mem_we_o=1 and mem_wdata_o. Writes produce no rvalid.
- A read pushes a 2-deep tag pipeline: valid bit plus requester id.
- Idle cycles drive mem_we_o=0 and hold mem_addr_o.

## Timing
- Grant in cycle N: mem_addr_o and mem_we_o are valid for all of cycle N+1.
- The memory samples on the negedge inside N+1.
- The arbiter registers mem_rdata_i at the posedge ending N+1.
- rdata_o and the matching rvalid pulse are valid in cycle N+2. Read latency is 2 cycles from grant.
- Back-to-back grants, one per cycle, sustain full throughput. The two rvalid outputs are never high together.
- Write at N followed by a read of the same address at N+1 returns the new data. The memory writes before it reads.
- Reset values:
  - gnt, rvalid, mem_we_o: 0.
  - mem_addr_o, mem_wdata_o, rdata_o: 0.
  - state: ARB; burst_cnt: 0; last_gnt: DBG.
- Reset mid-operation flushes the tag pipeline. No rvalid is produced for reads in flight.

## Structure
- wi23_defs supplies IMEM_DEPTH and IMEM_WIDTH.
- Add to wi23_defs:
  - enum imem_arb_state_t {ARB, DBG_BURST, CPU_YIELD}.
  - enum imem_req_id_t {REQ_CPU, REQ_DBG}.
- Sub-module imem_rd_tag_pipe: the 2-stage valid/id shift register that generates the rvalid pulses.

## Test plan
- CPU only, reads 0x010, 0x011, 0x012 on consecutive cycles -> gnt in cycles 0–2; cpu_rvalid in cycles 2–4 with mem[0x010..0x012] in order.
- Both request every cycle, no lock -> grants alternate CPU, DBG, CPU, DBG…, CPU first after reset; never both high.
- Debug writes 0xBEEF to 0x020, then reads 0x020 the next cycle -> mem_we_o=1 for one cycle; dbg_rvalid two cycles later with rdata_o=0xBEEF; no cpu_rvalid.
- dbg_lock_i=1 with both requesting continuously, MAX_BURST=8 -> 8 debug grants, 1 CPU grant, 8 debug grants, repeating; burst_cnt never exceeds 8.
- Lock held, CPU idle, 20 debug grants -> burst_cnt saturates at 8 and no CPU_YIELD occurs. Then raise cpu_req_i -> CPU granted in the next cycle.
- Assert rst one cycle after two read grants -> no rvalid pulses afterwards; all outputs 0; the first post-reset tie goes to the CPU.
